// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter for the register file's single write port
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Hold,
  input  logic              AValid,
  input  logic [ADDR_W-1:0] ASelect,
  input  logic [DATA_W-1:0] AData,
  output logic              AReady,
  input  logic              BValid,
  input  logic [ADDR_W-1:0] BSelect,
  input  logic [DATA_W-1:0] BData,
  output logic              BReady,
  output logic [ADDR_W-1:0] WriteSelect,
  output logic [DATA_W-1:0] WriteData,
  output logic              WriteEnable,
  input  logic [ADDR_W-1:0] PendingSel,
  output logic              Pending,
  output logic [CNT_W-1:0]  AStallCount,
  output logic [CNT_W-1:0]  BStallCount
);
  typedef enum logic {GRANT_A, GRANT_B} grantT;
  grantT lastGrant;
  logic take;
  logic [ADDR_W-1:0] winSel;
  logic [DATA_W-1:0] winData;
  always_comb begin
    AReady = !Hold && AValid && (!BValid || lastGrant == GRANT_B);
    BReady = !Hold && BValid && (!AValid || lastGrant == GRANT_A);
    take = AReady || BReady;
    winSel = AReady ? ASelect : BSelect;
    winData = AReady ? AData : BData;
  end
  assign Pending = WriteEnable && (WriteSelect == PendingSel) && (PendingSel != '0);
  // writes to r0 are accepted but never reach the register file
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lastGrant <= GRANT_B;
      WriteEnable <= 1'b0;
      WriteSelect <= '0;
      WriteData <= '0;
      AStallCount <= '0;
      BStallCount <= '0;
    end else begin
      WriteEnable <= take && (winSel != '0);
      if (take) begin
        lastGrant <= AReady ? GRANT_A : GRANT_B;
        WriteSelect <= winSel;
        WriteData <= winData;
      end
      if (AValid && !AReady && AStallCount != '1) AStallCount <= AStallCount + 1'b1;
      if (BValid && !BReady && BStallCount != '1) BStallCount <= BStallCount + 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed vector table plus hand sequences for hold, saturation and reset
module tb_regfile_write_arbiter;
  logic Clk = 0, Reset = 1, Hold = 0;
  logic AValid = 0, BValid = 0, AReady, BReady, WriteEnable, Pending;
  logic [4:0] ASelect = 0, BSelect = 0, WriteSelect, PendingSel = 0;
  logic [31:0] AData = 0, BData = 0, WriteData;
  logic [3:0] AStallCount, BStallCount;
  int tests = 0, fails = 0;

  regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .Hold(Hold),
    .AValid(AValid), .ASelect(ASelect), .AData(AData), .AReady(AReady),
    .BValid(BValid), .BSelect(BSelect), .BData(BData), .BReady(BReady),
    .WriteSelect(WriteSelect), .WriteData(WriteData), .WriteEnable(WriteEnable),
    .PendingSel(PendingSel), .Pending(Pending),
    .AStallCount(AStallCount), .BStallCount(BStallCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic hold, av;
    logic [4:0] as;
    logic [31:0] ad;
    logic bv;
    logic [4:0] bs;
    logic [31:0] bd;
    logic [4:0] ps;
    logic ear, ebr, ewe;
    logic [4:0] ews;
    logic [31:0] ewd;
    logic ep, cw;
  } vec_t;

  vec_t tv[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic h, input logic av, input logic [4:0] as, input logic [31:0] ad,
                       input logic bv, input logic [4:0] bs, input logic [31:0] bd, input logic [4:0] ps);
    Hold = h; AValid = av; ASelect = as; AData = ad;
    BValid = bv; BSelect = bs; BData = bd; PendingSel = ps;
  endtask

  initial begin
    for (int i = 0; i < 6; i++)
      tv[i] = (i % 2 == 0)
        ? '{1'b0, 1'b1, 5'd3, 32'hAAAA0000, 1'b1, 5'd4, 32'hBBBB0000, 5'd3, 1'b1, 1'b0, 1'b1, 5'd3, 32'hAAAA0000, 1'b1, 1'b1}
        : '{1'b0, 1'b1, 5'd3, 32'hAAAA0000, 1'b1, 5'd4, 32'hBBBB0000, 5'd3, 1'b0, 1'b1, 1'b1, 5'd4, 32'hBBBB0000, 1'b0, 1'b1};
    tv[6]  = '{1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0};
    tv[7]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 32'h77, 1'b1, 1'b1};
    tv[8]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h99, 5'd8, 1'b0, 1'b1, 1'b1, 5'd7, 32'h99, 1'b0, 1'b1};
    tv[9]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7, 1'b0, 1'b0, 1'b0, 5'd7, 32'h99, 1'b0, 1'b1};
    tv[10] = '{1'b1, 1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0, 5'd7, 32'h99, 1'b0, 1'b1};
    tv[11] = '{1'b0, 1'b1, 5'd9, 32'hA9, 1'b1, 5'd9, 32'hB9, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9, 32'hA9, 1'b1, 1'b1};
    tv[12] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hB9, 5'd9, 1'b0, 1'b1, 1'b1, 5'd9, 32'hB9, 1'b1, 1'b1};

    drive(0, 1, 5'd3, 32'hAAAA0000, 1, 5'd4, 32'hBBBB0000, 5'd3);
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_we", WriteEnable, 0);
    chk("reset_acnt", AStallCount, 0);
    chk("reset_bcnt", BStallCount, 0);
    chk("reset_pending", Pending, 0);
    chk("reset_aready", AReady, 1);
    chk("reset_bready", BReady, 0);
    Reset = 0;

    for (int i = 0; i < 13; i++) begin
      drive(tv[i].hold, tv[i].av, tv[i].as, tv[i].ad, tv[i].bv, tv[i].bs, tv[i].bd, tv[i].ps);
      #1;
      chk($sformatf("v%0d_aready", i), AReady, tv[i].ear);
      chk($sformatf("v%0d_bready", i), BReady, tv[i].ebr);
      @(posedge Clk);
      #1;
      chk($sformatf("v%0d_we", i), WriteEnable, tv[i].ewe);
      chk($sformatf("v%0d_pending", i), Pending, tv[i].ep);
      if (tv[i].cw) begin
        chk($sformatf("v%0d_wsel", i), WriteSelect, tv[i].ews);
        chk($sformatf("v%0d_wdata", i), WriteData, tv[i].ewd);
      end
      if (i == 5) begin
        chk("contention_acnt", AStallCount, 3);
        chk("contention_bcnt", BStallCount, 3);
      end
    end
    chk("table_acnt", AStallCount, 4);
    chk("table_bcnt", BStallCount, 4);

    drive(1, 1, 5'd3, 32'hAAAA0000, 1, 5'd4, 32'hBBBB0000, 5'd3);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("hold_aready", AReady, 0);
      chk("hold_bready", BReady, 0);
      @(posedge Clk);
      #1;
      chk("hold_we", WriteEnable, 0);
    end
    chk("hold_acnt", AStallCount, 8);
    chk("hold_bcnt", BStallCount, 8);
    Hold = 0;
    #1;
    chk("release_aready", AReady, 1);
    chk("release_bready", BReady, 0);
    @(posedge Clk);
    #1;
    chk("release_wsel", WriteSelect, 3);
    chk("release_bcnt", BStallCount, 9);

    drive(1, 0, 5'd0, 32'h0, 1, 5'd6, 32'h66, 5'd6);
    repeat (20) @(posedge Clk);
    #1;
    chk("sat_bcnt", BStallCount, 15);
    chk("sat_acnt", AStallCount, 8);
    Hold = 0;
    @(posedge Clk);
    #1;
    chk("sat_hold_bcnt", BStallCount, 15);
    chk("pre_reset_we", WriteEnable, 1);
    chk("pre_reset_pending", Pending, 1);
    Reset = 1;
    #1;
    chk("async_reset_we", WriteEnable, 0);
    chk("async_reset_pending", Pending, 0);
    chk("async_reset_acnt", AStallCount, 0);
    chk("async_reset_bcnt", BStallCount, 0);
    chk("async_reset_wsel", WriteSelect, 0);
    Reset = 0;
    @(posedge Clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Two-requester arbiter for the register file's single write port. The ALU write-back (requester A) and the load/memory write-back (requester B) each present a destination register and data under a valid/ready handshake. The block grants one request per cycle round-robin and drives the registered WriteSelect/WriteData/WriteEnable into the register file. It also exposes an in-flight hazard query and per-requester stall counters for debug.

## Interface

Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register select width (32 registers; register 0 is hard-wired zero)
- CNT_W, 16, stall counter width

Ports:
- Clk  in  1  single clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high; clears all state immediately
- Hold  in  1  pipeline stall; no grants while high
- AValid  in  1  requester A has a write pending
- ASelect  in  ADDR_W  requester A destination register
- AData  in  DATA_W  requester A write data
- AReady  out  1  A accepted this cycle (combinational)
- BValid, BSelect, BData, BReady: same as A, for requester B
- WriteSelect  out  ADDR_W  to register file, registered
- WriteData  out  DATA_W  to register file, registered
- WriteEnable  out  1  to register file, registered
- PendingSel  in  ADDR_W  hazard query address
- Pending  out  1  combinational: a write to PendingSel is in flight
- AStallCount  out  CNT_W  cycles with AValid and not AReady, saturating
- BStallCount  out  CNT_W  cycles with BValid and not BReady, saturating

## Operation

- Transfer on a requester = Valid and Ready high at a rising Clk edge.
- Arbitration state: LastGrant register, values GRANT_A / GRANT_B. Reset value GRANT_B, so A wins the first contention.
- Grant rules, evaluated each cycle:
  - Hold=1: AReady=BReady=0.
  - Only AValid: AReady=1.
  - Only BValid: BReady=1.
  - Both valid: grant the requester not equal to LastGrant.
  - Neither valid: no grant.
- Ready is never asserted without the matching Valid. At most one Ready is high per cycle.
- LastGrant updates only on a transfer, to the granted requester. Idle and Hold cycles leave it unchanged.
- On a transfer, the next edge loads WriteSelect/WriteData from the winner and sets WriteEnable=1. Exception: if the winner's Select is 0, the request is accepted (Ready=1) but WriteEnable=0, so the write is silently dropped.
- With no transfer, WriteEnable=0 next cycle. WriteSelect/WriteData hold their last values.
- Pending = WriteEnable and (WriteSelect == PendingSel) and (PendingSel != 0).
- Stall counters: increment when Valid=1 and Ready=0, including Hold cycles. Saturate at all-ones and never wrap.

## Timing

- Reset (async, any time) forces:
  - WriteEnable=0, WriteSelect=0, WriteData=0
  - LastGrant=GRANT_B
  - both stall counters=0
  - Pending=0
  - AReady/BReady follow the combinational rules (combinationally 1 if Valid is high, Hold is low, and the requester is selected). A write already registered is discarded: WriteEnable drops asynchronously.
- Latency: a request accepted at edge N appears on WriteEnable/WriteSelect/WriteData during cycle N+1. The register file commits it at edge N+1.
- Throughput: one write per cycle. Under continuous contention, grants alternate A, B, A, B.
- Hold asserted during cycle N: no transfer at edge N, WriteEnable=0 in cycle N+1. An already-registered write is not cancelled.
- Requesters must keep Valid/Select/Data stable until Ready. The block does not buffer.
- Same destination from A and B in the same cycle: arbitration decides order; the loser writes one or more cycles later and its value persists.
- Reset release: first grant possible at the first rising edge with Reset low.

## Test plan

- Reset: Reset=1 with AValid=BValid=1 → WriteEnable=0, both counters 0, Pending=0. After release, first edge grants A; cycle 1 shows WriteSelect=ASelect, WriteEnable=1.
- Contention: AValid=BValid=1 for 6 cycles, ASelect=3/AData=0xAAAA0000, BSelect=4/BData=0xBBBB0000 → WriteSelect sequence 3,4,3,4,3,4. BStallCount=3 and AStallCount=3 (A stalled on B's turns).
- Register 0: AValid=1, ASelect=0, AData=0xFFFFFFFF → AReady=1, next cycle WriteEnable=0, Pending=0 for PendingSel=0.
- Hold: both valid, Hold=1 for 4 cycles → no Ready, WriteEnable=0, both counters +4, LastGrant unchanged. On release, the previously favoured requester wins.
- Hazard: accept B write to r7. In cycle N+1, PendingSel=7 → Pending=1; PendingSel=8 → Pending=0. Cycle N+2 with no transfer → Pending=0.
- Saturation and mid-op reset: CNT_W=4, BValid held with A winning... force B stalls for 20 cycles via Hold → BStallCount=15 (no wrap). Assert Reset while WriteEnable=1 → WriteEnable drops immediately, counters return to 0.
